wb_fabric_dec: RTL and testbench
================================

WB_FABRIC_DEC -- requirements
Module: wb_fabric_dec

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8, number of routed Wishbone slaves (1..32).
REQ-002 SHALL have parameter SLV_BASE, default all-zero, NUM_SLAVES*32-bit flattened base addresses, slave 0 in LSBs.
REQ-003 SHALL have parameter SLV_MASK, default all-zero, NUM_SLAVES*32-bit flattened compare masks; an all-zero mask matches any address.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, cycles without slave ack/err before a forced error (1..65535).
REQ-005 i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_wb_cyc  input  1  master cycle.
REQ-008 i_wb_stb  input  1  master strobe.
REQ-009 i_wb_adr  input  32  master byte address.
REQ-010 o_wb_ack  output  1  ack to master.
REQ-011 o_wb_err  output  1  error to master.
REQ-012 o_wb_dat  output  32  read data to master.
REQ-013 o_slv_cyc  output  NUM_SLAVES  per-slave cycle.
REQ-014 o_slv_stb  output  NUM_SLAVES  per-slave strobe.
REQ-015 i_slv_ack  input  NUM_SLAVES  per-slave ack.
REQ-016 i_slv_err  input  NUM_SLAVES  per-slave error.
REQ-017 i_slv_dat  input  NUM_SLAVES*32  flattened slave read data.
REQ-018 o_err_pulse  output  1  one-cycle pulse per decode or timeout error.

Function
REQ-019 Slave i SHALL match when (i_wb_adr & mask_i) == (base_i & mask_i); lowest matching index wins.
REQ-020 States SHALL be IDLE, ACTIVE, ERR.
REQ-021 IDLE: on i_wb_cyc & i_wb_stb with a match, SHALL register one-hot select and enter ACTIVE; no slave strobe this cycle (one added cycle on first beat).
REQ-022 IDLE: on i_wb_cyc & i_wb_stb with no match, SHALL enter ERR.
REQ-023 ACTIVE: o_slv_cyc/o_slv_stb of selected slave SHALL equal i_wb_cyc/i_wb_stb combinationally; all others 0.
REQ-024 ACTIVE: o_wb_ack, o_wb_err, o_wb_dat SHALL combinationally mirror the selected slave; zero added latency on subsequent beats.
REQ-025 Select SHALL stay latched while i_wb_cyc is high, regardless of address changes (bursts never re-decode).
REQ-026 ACTIVE: i_wb_cyc low SHALL return to IDLE next cycle, clearing select and timeout counter.
REQ-027 ERR: o_wb_err=1 and o_err_pulse=1 for exactly one cycle, no slave strobed, then IDLE.
REQ-028 Outside ACTIVE, o_wb_ack=0 and o_wb_dat=0; o_wb_err=0 except in ERR.
REQ-029 Simultaneous i_slv_ack and i_slv_err from the selected slave SHALL forward both; master treats err as dominant.
REQ-030 Responses from unselected slaves SHALL be ignored.

Reset
REQ-031 i_rst_n low SHALL asynchronously force IDLE, select=0, counter=0; all outputs 0.
REQ-032 Reset mid-cycle SHALL abort the transfer with no ack/err issued.

Configuration
REQ-033 Macro WB_FABRIC_DEC_TIMEOUT_EN defined: 16-bit counter increments each ACTIVE cycle with i_wb_stb high and no selected ack/err, clears on ack/err; reaching TIMEOUT_CYCLES SHALL drop slave cyc/stb and enter ERR.
REQ-034 Macro undefined: no counter; ACTIVE waits indefinitely for slave response.

Structure
REQ-035 Shared package wb_fabric_pkg SHALL hold state encoding (IDLE/ACTIVE/ERR) and counter width constant.
REQ-036 Timeout counter SHALL be sub-module wb_fabric_wdog (enable, clear, expire output).

Verification
REQ-037 Slave0 base FFFEFFE0 mask FFFFFFE0; single read FFFEFFE4 -> slave0 stb one cycle after master stb, ack+dat A5A5A5A5 returned same cycle as slave ack.
REQ-038 Address 00001000, no match, no all-zero mask -> o_wb_err and o_err_pulse high exactly one cycle, no o_slv_stb.
REQ-039 Overlapping slaves 2 and 5 both match -> only slave 2 strobed.
REQ-040 4-beat burst starting in slave 1, address crosses into slave 3 range -> all beats to slave 1.
REQ-041 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> err after 8 stalled cycles, slave cyc dropped, back to IDLE.
REQ-042 i_rst_n low during ACTIVE -> outputs 0 immediately, next access decodes normally.

Source files
------------

// File: rtl/wb_fabric_pkg.sv
// Shared definitions for the Wishbone address-decode fabric.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package wb_fabric_pkg;

  // Decoder FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  // Watchdog counter width; bounds the usable timeout to 1..65535 cycles.
  localparam int WDOG_CNT_W = 16;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Masked compare: an all-zero mask matches any address.
  function automatic logic addr_match(input logic [ADDR_W-1:0] adr,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] mask);
    return ((adr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/wb_fabric_wdog.sv
// Stall watchdog for the decoder: counts stalled cycles and flags expiry.
// Latency: expire is combinational in the LIMIT-th consecutive stalled cycle.
// Backpressure: none; holds its count while neither enabled nor cleared.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : stalled cycle (strobe pending, no ack/err)
//   i_clr          : clear the count (response seen or not in a transfer)
//   o_expire       : this stalled cycle is the LIMIT-th one
module wb_fabric_wdog
  import wb_fabric_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam logic [WDOG_CNT_W-1:0] LAST = WDOG_CNT_W'(LIMIT - 1);

  logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The count reaches LIMIT on the edge that moves the decoder into ERR.
  assign o_expire = i_en & ~i_clr & (cnt_q == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_fabric_dec.sv
// Wishbone 1:N address decoder with latched slave select and error response.
// Latency: +1 cycle on the first beat of a cycle (decode), 0 on later beats.
// Backpressure: slave ack/err pass straight through; master waits on them.
//
// Ports: i_clk/i_rst_n; master i_wb_cyc/stb/adr -> o_wb_ack/err/dat;
//   per-slave o_slv_cyc/stb <- i_slv_ack/err/dat (flattened, slave 0 in LSBs);
//   o_err_pulse marks each decode or timeout error.
// Build option: define WB_FABRIC_DEC_TIMEOUT_EN to abort stalled transfers
//   after TIMEOUT_CYCLES cycles; otherwise ACTIVE waits indefinitely.
module wb_fabric_dec
  import wb_fabric_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = '0,
  parameter int                       TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic [31:0]              i_wb_adr,
  output logic                     o_wb_ack,
  output logic                     o_wb_err,
  output logic [31:0]              o_wb_dat,
  output logic [NUM_SLAVES-1:0]    o_slv_cyc,
  output logic [NUM_SLAVES-1:0]    o_slv_stb,
  input  logic [NUM_SLAVES-1:0]    i_slv_ack,
  input  logic [NUM_SLAVES-1:0]    i_slv_err,
  input  logic [NUM_SLAVES*32-1:0] i_slv_dat,
  output logic                     o_err_pulse
);

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;

  logic [NUM_SLAVES-1:0] hit_onehot;
  logic                  hit_any;
  logic                  sel_ack, sel_err;
  logic [31:0]           sel_dat;
  logic                  active;
  logic                  wdog_expire;

  assign active = (state_q == ST_ACTIVE);

  // Priority decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_onehot = '0;
    hit_any    = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_match(i_wb_adr, SLV_BASE[i*32 +: 32], SLV_MASK[i*32 +: 32])) begin
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        hit_any       = 1'b1;
      end
    end
  end

  // Only the latched slave's response is visible; everything else is masked.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_dat = sel_dat | i_slv_dat[i*32 +: 32];
      end
    end
  end

  assign sel_ack = |(i_slv_ack & sel_q);
  assign sel_err = |(i_slv_err & sel_q);

`ifdef WB_FABRIC_DEC_TIMEOUT_EN
  logic wdog_en, wdog_clr;

  assign wdog_en  = active & i_wb_cyc & i_wb_stb & ~sel_ack & ~sel_err;
  assign wdog_clr = ~(active & i_wb_cyc) | sel_ack | sel_err;

  wb_fabric_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (wdog_en),
    .i_clr    (wdog_clr),
    .o_expire (wdog_expire)
  );
`else
  logic unused_tmo;

  assign wdog_expire = 1'b0;
  assign unused_tmo  = ^(WDOG_CNT_W'(TIMEOUT_CYCLES));
`endif

  // Slave side is a pure pass-through of the master handshake while ACTIVE.
  assign o_slv_cyc = active ? (sel_q & {NUM_SLAVES{i_wb_cyc}}) : '0;
  assign o_slv_stb = active ? (sel_q & {NUM_SLAVES{i_wb_stb}}) : '0;

  assign o_wb_ack    = active & sel_ack;
  assign o_wb_err    = (active & sel_err) | (state_q == ST_ERR);
  assign o_wb_dat    = active ? sel_dat : '0;
  assign o_err_pulse = (state_q == ST_ERR);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          if (hit_any) begin
            sel_d   = hit_onehot;
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        // Select holds for the whole cycle; bursts never re-decode.
        if (!i_wb_cyc) begin
          sel_d   = '0;
          state_d = ST_IDLE;
        end else if (wdog_expire) begin
          sel_d   = '0;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_wb_fabric_dec.sv
// Self-checking bench for wb_fabric_dec: scripted master, registered-ack
// slave models, expected responses queued at issue and compared on return.
// Covers reset, decode priority, bursts, errors, timeout and mid-cycle reset.
module tb_wb_fabric_dec;

  localparam int NS = 8;

  localparam logic [NS*32-1:0] BASE = {
    32'h0005_0000, 32'h0004_0000, 32'h0002_0000, 32'h0003_0000,
    32'h0001_1000, 32'h0002_0000, 32'h0001_0000, 32'hFFFE_FFE0};
  localparam logic [NS*32-1:0] MASK = {
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_0000,
    32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_FFE0};

  typedef struct {
    logic          ack;
    logic          err;
    logic [31:0]   dat;
    logic [NS-1:0] stb;
    logic          pulse;
  } exp_t;

  exp_t sb[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic [31:0]   adr = '0;
  logic          o_wb_ack, o_wb_err, o_err_pulse;
  logic [31:0]   o_wb_dat;
  logic [NS-1:0] o_slv_cyc, o_slv_stb;
  logic [NS-1:0] slv_ack, slv_err;
  logic [NS*32-1:0] slv_dat = '0;

  logic [NS-1:0] ack_r = '0;
  logic [NS-1:0] dead  = '0;
  logic [NS-1:0] both  = '0;
  logic [NS-1:0] noise = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_fabric_dec #(
    .NUM_SLAVES     (NS),
    .SLV_BASE       (BASE),
    .SLV_MASK       (MASK),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wb_cyc    (cyc),
    .i_wb_stb    (stb),
    .i_wb_adr    (adr),
    .o_wb_ack    (o_wb_ack),
    .o_wb_err    (o_wb_err),
    .o_wb_dat    (o_wb_dat),
    .o_slv_cyc   (o_slv_cyc),
    .o_slv_stb   (o_slv_stb),
    .i_slv_ack   (slv_ack),
    .i_slv_err   (slv_err),
    .i_slv_dat   (slv_dat),
    .o_err_pulse (o_err_pulse)
  );

  // Slaves ack one cycle after seeing their strobe; noise drives unselected lines.
  always @(posedge clk) ack_r <= o_slv_stb & ~ack_r & ~dead;
  assign slv_ack = ack_r | noise;
  assign slv_err = (ack_r & both) | noise;

  function automatic logic [31:0] sdat(input int k);
    return (k == 0) ? 32'hA5A5_A5A5 : (32'hC0DE_0000 | 32'(k));
  endfunction

  // Issue one beat and wait (bounded) for ack/err; stb is released afterwards.
  task automatic run_beat(input logic [31:0] a,
                          output logic g_ack, output logic g_err,
                          output logic [31:0] g_dat, output logic g_pulse,
                          output logic [NS-1:0] g_stb, output logic [NS-1:0] g_pre,
                          output logic [NS-1:0] g_scyc, output int g_cyc,
                          output int g_first, output int g_nstb, output logic g_to);
    cyc = 1'b1; stb = 1'b1; adr = a;
    g_ack = 0; g_err = 0; g_dat = '0; g_pulse = 0; g_stb = '0; g_scyc = '0;
    g_cyc = 0; g_first = -1; g_nstb = 0; g_to = 1'b1;
    #1 g_pre = o_slv_stb;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      g_stb = g_stb | o_slv_stb;
      if (o_slv_stb != '0) begin
        g_nstb++;
        if (g_first < 0) g_first = n;
      end
      if (o_wb_ack || o_wb_err) begin
        g_ack = o_wb_ack; g_err = o_wb_err; g_dat = o_wb_dat;
        g_pulse = o_err_pulse; g_scyc = o_slv_cyc; g_cyc = n; g_to = 1'b0;
        break;
      end
    end
    stb = 1'b0;
  endtask

  task automatic end_cycle();
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  logic          g_ack, g_err, g_pulse, g_to;
  logic [31:0]   g_dat;
  logic [NS-1:0] g_stb, g_pre, g_scyc;
  int            g_cyc, g_first, g_nstb;
  exp_t          e;

  task automatic test_reset();
    noise = '1;
    cyc = 1'b1; stb = 1'b1; adr = 32'hFFFE_FFE4;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_err_pulse, o_wb_dat, o_slv_cyc, o_slv_stb} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got ack=%b err=%b pulse=%b dat=%h cyc=%b stb=%b want all 0",
                        o_wb_ack, o_wb_err, o_err_pulse, o_wb_dat, o_slv_cyc, o_slv_stb);
    end
    cyc = 1'b0; stb = 1'b0; noise = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_err_pulse, o_slv_cyc} !== '0) begin
      n_bad++; $display("FAIL idle_after_reset got ack=%b err=%b pulse=%b cyc=%b want 0",
                        o_wb_ack, o_wb_err, o_err_pulse, o_slv_cyc);
    end
  endtask

  task automatic test_single_read();
    noise = ~8'h01;
    sb.push_back('{1'b1, 1'b0, 32'hA5A5_A5A5, 8'h01, 1'b0});
    run_beat(32'hFFFE_FFE4, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++; if (g_to !== 1'b0) begin n_bad++; $display("FAIL rd0_timeout no response within 40 cycles"); end
    n_cmp++; if (g_pre !== 8'h00) begin n_bad++; $display("FAIL rd0_decode_cycle_stb got=%b want=00000000", g_pre); end
    n_cmp++; if (g_first !== 1) begin n_bad++; $display("FAIL rd0_stb_latency got=%0d want=1", g_first); end
    n_cmp++; if (g_cyc !== 2) begin n_bad++; $display("FAIL rd0_ack_latency got=%0d want=2", g_cyc); end
    n_cmp++; if ({g_ack, g_err} !== {e.ack, e.err}) begin n_bad++; $display("FAIL rd0_ack_err got=%b%b want=%b%b", g_ack, g_err, e.ack, e.err); end
    n_cmp++; if (g_dat !== e.dat) begin n_bad++; $display("FAIL rd0_dat got=%h want=%h", g_dat, e.dat); end
    n_cmp++; if (g_stb !== e.stb) begin n_bad++; $display("FAIL rd0_stb_mask got=%b want=%b", g_stb, e.stb); end
    end_cycle();
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_wb_dat, o_slv_cyc} !== '0) begin
      n_bad++; $display("FAIL rd0_idle_masked got ack=%b err=%b dat=%h cyc=%b want 0", o_wb_ack, o_wb_err, o_wb_dat, o_slv_cyc);
    end
    noise = '0;
  endtask

  task automatic test_decode_err();
    sb.push_back('{1'b0, 1'b1, 32'h0, 8'h00, 1'b1});
    run_beat(32'h0000_1000, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++; if (g_cyc !== 1) begin n_bad++; $display("FAIL decerr_latency got=%0d want=1", g_cyc); end
    n_cmp++;
    if ({g_ack, g_err, g_pulse} !== {e.ack, e.err, e.pulse}) begin
      n_bad++; $display("FAIL decerr_resp got ack=%b err=%b pulse=%b want %b %b %b", g_ack, g_err, g_pulse, e.ack, e.err, e.pulse);
    end
    n_cmp++; if (g_stb !== e.stb) begin n_bad++; $display("FAIL decerr_no_stb got=%b want=%b", g_stb, e.stb); end
    end_cycle();
    n_cmp++;
    if ({o_wb_err, o_err_pulse} !== 2'b00) begin
      n_bad++; $display("FAIL decerr_one_cycle got err=%b pulse=%b want 0 0", o_wb_err, o_err_pulse);
    end
  endtask

  task automatic test_decode_table();
    logic [31:0] addrs[5] = '{32'h0002_0010, 32'h0001_1004, 32'h0004_0008, 32'h0005_1000, 32'h0001_0FFC};
    int          idxs[5]  = '{2, 3, 6, 7, 1};
    for (int t = 0; t < 5; t++) begin
      logic [NS-1:0] oh;
      oh = '0; oh[idxs[t]] = 1'b1;
      noise = ~oh;
      sb.push_back('{1'b1, 1'b0, sdat(idxs[t]), oh, 1'b0});
      run_beat(addrs[t], g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
      e = sb.pop_front();
      n_cmp++;
      if ({g_to, g_ack, g_err, g_dat, g_stb} !== {1'b0, e.ack, e.err, e.dat, e.stb}) begin
        n_bad++; $display("FAIL dec_%0h got to=%b ack=%b err=%b dat=%h stb=%b want to=0 ack=%b err=%b dat=%h stb=%b",
                          addrs[t], g_to, g_ack, g_err, g_dat, g_stb, e.ack, e.err, e.dat, e.stb);
      end
      end_cycle();
    end
    noise = '0;
  endtask

  task automatic test_burst();
    logic [31:0] beats[4] = '{32'h0001_0FF8, 32'h0001_0FFC, 32'h0001_1000, 32'h0001_1004};
    for (int b = 0; b < 4; b++) sb.push_back('{1'b1, 1'b0, sdat(1), 8'h02, 1'b0});
    for (int b = 0; b < 4; b++) begin
      run_beat(beats[b], g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
      e = sb.pop_front();
      n_cmp++;
      if ({g_to, g_ack, g_dat, g_stb} !== {1'b0, e.ack, e.dat, e.stb}) begin
        n_bad++; $display("FAIL burst_beat%0d got to=%b ack=%b dat=%h stb=%b want to=0 ack=%b dat=%h stb=%b",
                          b, g_to, g_ack, g_dat, g_stb, e.ack, e.dat, e.stb);
      end
    end
    end_cycle();
  endtask

  task automatic test_ack_err();
    both = 8'h10;
    sb.push_back('{1'b1, 1'b1, sdat(4), 8'h10, 1'b0});
    run_beat(32'h0003_1234, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++;
    if ({g_ack, g_err, g_pulse, g_dat} !== {e.ack, e.err, e.pulse, e.dat}) begin
      n_bad++; $display("FAIL ackerr_both got ack=%b err=%b pulse=%b dat=%h want %b %b %b %h",
                        g_ack, g_err, g_pulse, g_dat, e.ack, e.err, e.pulse, e.dat);
    end
    end_cycle();
    both = '0;
  endtask

  task automatic test_timeout();
    dead = 8'h80;
`ifdef WB_FABRIC_DEC_TIMEOUT_EN
    sb.push_back('{1'b0, 1'b1, 32'h0, 8'h80, 1'b1});
    run_beat(32'h0005_0000, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++; if (g_cyc !== 9) begin n_bad++; $display("FAIL tmo_latency got=%0d want=9", g_cyc); end
    n_cmp++; if (g_nstb !== 8) begin n_bad++; $display("FAIL tmo_stalled_cycles got=%0d want=8", g_nstb); end
    n_cmp++;
    if ({g_ack, g_err, g_pulse, g_scyc} !== {e.ack, e.err, e.pulse, 8'h00}) begin
      n_bad++; $display("FAIL tmo_resp got ack=%b err=%b pulse=%b slv_cyc=%b want %b %b %b 00000000",
                        g_ack, g_err, g_pulse, g_scyc, e.ack, e.err, e.pulse);
    end
    end_cycle();
    n_cmp++; if (o_wb_err !== 1'b0) begin n_bad++; $display("FAIL tmo_back_idle got err=%b want 0", o_wb_err); end
`else
    begin
      logic seen;
      seen = 1'b0;
      cyc = 1'b1; stb = 1'b1; adr = 32'h0005_0000;
      repeat (30) begin
        @(negedge clk);
        if (o_wb_ack || o_wb_err) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL notmo_no_resp got resp=1 want 0"); end
      n_cmp++; if (o_slv_stb !== 8'h80) begin n_bad++; $display("FAIL notmo_still_stb got=%b want=10000000", o_slv_stb); end
      end_cycle();
      n_cmp++; if (o_slv_cyc !== 8'h00) begin n_bad++; $display("FAIL notmo_release got=%b want 0", o_slv_cyc); end
    end
`endif
    dead = '0;
    sb.push_back('{1'b1, 1'b0, sdat(7), 8'h80, 1'b0});
    run_beat(32'h0005_0004, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++;
    if ({g_to, g_ack, g_dat} !== {1'b0, e.ack, e.dat}) begin
      n_bad++; $display("FAIL tmo_recover got to=%b ack=%b dat=%h want 0 %b %h", g_to, g_ack, g_dat, e.ack, e.dat);
    end
    end_cycle();
  endtask

  task automatic test_reset_mid();
    logic seen;
    cyc = 1'b1; stb = 1'b1; adr = 32'h0001_0000;
    @(negedge clk);
    n_cmp++; if (o_slv_stb !== 8'h02) begin n_bad++; $display("FAIL rstmid_pre got=%b want=00000010", o_slv_stb); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_wb_ack, o_wb_err, o_err_pulse, o_wb_dat, o_slv_cyc, o_slv_stb} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs got ack=%b err=%b cyc=%b stb=%b want 0", o_wb_ack, o_wb_err, o_slv_cyc, o_slv_stb);
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (o_wb_ack || o_wb_err) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_resp got resp=1 want 0"); end
    cyc = 1'b0; stb = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back('{1'b1, 1'b0, 32'hA5A5_A5A5, 8'h01, 1'b0});
    run_beat(32'hFFFE_FFE8, g_ack, g_err, g_dat, g_pulse, g_stb, g_pre, g_scyc, g_cyc, g_first, g_nstb, g_to);
    e = sb.pop_front();
    n_cmp++;
    if ({g_to, g_ack, g_dat, g_stb} !== {1'b0, e.ack, e.dat, e.stb} || g_cyc !== 2) begin
      n_bad++; $display("FAIL rstmid_next got to=%b ack=%b dat=%h stb=%b lat=%0d want 0 %b %h %b 2",
                        g_to, g_ack, g_dat, g_stb, g_cyc, e.ack, e.dat, e.stb);
    end
    end_cycle();
  endtask

  initial begin
    for (int k = 0; k < NS; k++) slv_dat[k*32 +: 32] = sdat(k);
    test_reset();
    test_single_read();
    test_decode_err();
    test_decode_table();
    test_burst();
    test_ack_err();
    test_timeout();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "simulation time limit");
  end

endmodule
